// File: rtl/branch_predict_unit.sv
// branch_predict_unit: fetch-time taken/target prediction from a 2-bit saturating BHT,
// execute-time resolution from S/Z/V, BHT training, one-cycle registered flush/redirect
// on mispredict, and saturating branch/mispredict statistics.
module branch_predict_unit #(
    parameter int         PC_W      = 16,
    parameter int         DISP_W    = 8,
    parameter int         BHT_DEPTH = 16,
    parameter logic [1:0] BHT_INIT  = 2'b01,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  if_pc,
    input  logic [15:0]      if_instr,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [15:0]      ex_instr,
    input  logic             ex_pred_taken,
    input  logic             flag_s,
    input  logic             flag_z,
    input  logic             flag_v,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    // Only cond codes 000-011 of the 10111 group are branches; the rest decode as "not a branch".
    function automatic logic is_uncond(input logic [15:0] instr);
        return instr[15:11] == 5'b10100;
    endfunction

    function automatic logic is_cond(input logic [15:0] instr);
        return (instr[15:11] == 5'b10111) && !instr[10];
    endfunction

    function automatic logic cond_met(input logic [1:0] c, input logic s, input logic z,
                                      input logic v);
        case (c)
            2'b00:   return z;
            2'b01:   return s ^ v;
            2'b10:   return z | (s ^ v);
            default: return !z;
        endcase
    endfunction

    // pc + 1 + sext(disp), wrapping modulo 2^PC_W.
    function automatic logic [PC_W-1:0] br_target(input logic [PC_W-1:0] pc,
                                                  input logic [15:0] instr);
        return pc + PC_W'(1) + PC_W'($signed(instr[DISP_W-1:0]));
    endfunction

    logic [BHT_DEPTH-1:0][1:0] bht_q, bht_d;
    logic                      flush_q, flush_d;
    logic [PC_W-1:0]           redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]          br_count_q, br_count_d;
    logic [CNT_W-1:0]          mispred_count_q, mispred_count_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic             ex_is_br, ex_actual, resolve, mispred;

    // Disp bits above the decode field are consumed only by the target adder in some widths.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{if_instr, ex_instr};

    // Fetch-side prediction: reads the registered BHT, so a same-cycle update is not visible.
    always_comb begin
        if_idx      = if_pc[IDX_W-1:0];
        pred_taken  = is_uncond(if_instr) | (is_cond(if_instr) & bht_q[if_idx][1]);
        pred_target = br_target(if_pc, if_instr);
    end

    // Execute-side resolve, BHT training and next-state for flush/redirect/counters.
    always_comb begin
        ex_idx    = ex_pc[IDX_W-1:0];
        ex_is_br  = is_uncond(ex_instr) | is_cond(ex_instr);
        ex_actual = is_uncond(ex_instr) | cond_met(ex_instr[9:8], flag_s, flag_z, flag_v);
        // The instruction in execute while flush is high is wrong-path and gets squashed.
        resolve   = ex_valid & ex_branch & ex_is_br & !flush_q;
        mispred   = resolve & (ex_actual != ex_pred_taken);

        bht_d           = bht_q;
        flush_d         = mispred;
        redirect_pc_d   = redirect_pc_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;

        if (mispred)
            redirect_pc_d = ex_actual ? br_target(ex_pc, ex_instr) : ex_pc + PC_W'(1);
        if (resolve && br_count_q != '1)
            br_count_d = br_count_q + CNT_W'(1);
        if (mispred && mispred_count_q != '1)
            mispred_count_d = mispred_count_q + CNT_W'(1);
        // Unconditional branches never train the table.
        if (resolve && is_cond(ex_instr)) begin
            if (ex_actual && bht_q[ex_idx] != 2'b11)
                bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
            else if (!ex_actual && bht_q[ex_idx] != 2'b00)
                bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
        end
    end

    // State registers; reset discards any in-flight resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bht_q           <= {BHT_DEPTH{BHT_INIT}};
            flush_q         <= 1'b0;
            redirect_pc_q   <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            bht_q           <= bht_d;
            flush_q         <= flush_d;
            redirect_pc_q   <= redirect_pc_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign flush         = flush_q;
    assign redirect_pc   = redirect_pc_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: a default-parameter DUT plus a CNT_W=2 copy on the same
// stimulus. A reference model predicts registered outputs per cycle into a queue; each test
// pops and compares them against the outputs captured after the edge.
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] if_pc, if_instr, ex_pc, ex_instr;
    logic        ex_valid, ex_branch, ex_pred_taken, flag_s, flag_z, flag_v;
    logic        pred_taken, flush, pred_taken_s, flush_s;
    logic [15:0] pred_target, redirect_pc, br_count, mispred_count;
    logic [15:0] pred_target_s, redirect_pc_s;
    logic [1:0]  br_count_s, mispred_count_s;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_instr(if_instr),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_pred_taken(ex_pred_taken), .flag_s(flag_s), .flag_z(flag_z), .flag_v(flag_v),
        .flush(flush), .redirect_pc(redirect_pc), .br_count(br_count),
        .mispred_count(mispred_count));

    branch_predict_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_instr(if_instr),
        .pred_taken(pred_taken_s), .pred_target(pred_target_s),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_pred_taken(ex_pred_taken), .flag_s(flag_s), .flag_z(flag_z), .flag_v(flag_v),
        .flush(flush_s), .redirect_pc(redirect_pc_s), .br_count(br_count_s),
        .mispred_count(mispred_count_s));

    typedef struct packed {
        logic        flush;
        logic [15:0] redir;
        logic [15:0] br;
        logic [15:0] mis;
        logic [1:0]  br_s;
        logic [1:0]  mis_s;
    } obs_t;

    obs_t exp_q[$];
    obs_t got_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state
    logic [1:0]  m_bht[16];
    logic        m_flush;
    logic [15:0] m_redir;
    int          m_br, m_mis, m_br_s, m_mis_s;
    logic        dummy;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
        m_flush = 0; m_redir = 0; m_br = 0; m_mis = 0; m_br_s = 0; m_mis_s = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        ex_valid = 0; ex_branch = 0; ex_pc = 0; ex_instr = 0; ex_pred_taken = 0;
        flag_s = 0; flag_z = 0; flag_v = 0; if_pc = 0; if_instr = 0;
        model_reset();
        exp_q.delete(); got_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
    endtask

    // Drive one execute-stage cycle, predict the registered result, capture it after the edge.
    // pre_pred is the fetch prediction sampled during the cycle, before the edge.
    task automatic exec(input logic v, input logic b, input logic [15:0] pc,
                        input logic [15:0] ins, input logic pt, input logic s,
                        input logic z, input logic fv, output logic pre_pred);
        logic isb, isc, act, res, mp;
        logic [15:0] tgt, sx;
        obs_t e, g;
        ex_valid = v; ex_branch = b; ex_pc = pc; ex_instr = ins; ex_pred_taken = pt;
        flag_s = s; flag_z = z; flag_v = fv;
        #1 pre_pred = pred_taken;
        isb = (ins[15:11] == 5'b10100);
        isc = (ins[15:11] == 5'b10111) && (ins[10:8] <= 3'd3);
        case (ins[10:8])
            3'd0: act = z;
            3'd1: act = s ^ fv;
            3'd2: act = z | (s ^ fv);
            default: act = !z;
        endcase
        if (isb) act = 1;
        sx  = {{8{ins[7]}}, ins[7:0]};
        tgt = pc + 16'd1 + sx;
        res = v && b && (isb || isc) && !m_flush;
        mp  = res && (act != pt);
        if (res) begin
            m_br++;
            if (m_br_s < 3) m_br_s++;
            if (mp) begin
                m_mis++;
                if (m_mis_s < 3) m_mis_s++;
            end
            if (isc) begin
                if (act && m_bht[pc[3:0]] != 2'b11) m_bht[pc[3:0]] = m_bht[pc[3:0]] + 2'b01;
                if (!act && m_bht[pc[3:0]] != 2'b00) m_bht[pc[3:0]] = m_bht[pc[3:0]] - 2'b01;
            end
        end
        m_flush = mp;
        if (mp) m_redir = act ? tgt : pc + 16'd1;
        e.flush = m_flush; e.redir = m_redir; e.br = m_br[15:0]; e.mis = m_mis[15:0];
        e.br_s = m_br_s[1:0]; e.mis_s = m_mis_s[1:0];
        exp_q.push_back(e);
        @(posedge clk); #1;
        g.flush = flush; g.redir = redirect_pc; g.br = br_count; g.mis = mispred_count;
        g.br_s = br_count_s; g.mis_s = mispred_count_s;
        got_q.push_back(g);
    endtask

    task automatic idle();
        exec(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, dummy);
    endtask

    task automatic test_reset();
        obs_t g;
        apply_reset();
        g.flush = flush; g.redir = redirect_pc; g.br = br_count; g.mis = mispred_count;
        g.br_s = br_count_s; g.mis_s = mispred_count_s;
        total++;
        if (g !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", g); end
        if_pc = 16'h0007; if_instr = 16'hB800; #1;
        total++;
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_bht: got %b want 0", pred_taken); end
    endtask

    task automatic test_fetch();
        if_pc = 16'h0010; if_instr = 16'hB805; #1;
        total++;
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL fetch_be_pred: got %b want 0", pred_taken); end
        total++;
        if (pred_target !== 16'h0016) begin bad++; $display("FAIL fetch_be_tgt: got %h want 0016", pred_target); end
        if_instr = 16'hBC05; #1;
        total++;
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL fetch_nonbr_pred: got %b want 0", pred_taken); end
        total++;
        if (pred_target !== 16'h0016) begin bad++; $display("FAIL fetch_nonbr_tgt: got %h want 0016", pred_target); end
        if_pc = 16'hFFFF; if_instr = 16'hA001; #1;
        total++;
        if (pred_taken !== 1'b1) begin bad++; $display("FAIL fetch_b_pred: got %b want 1", pred_taken); end
        total++;
        if (pred_target !== 16'h0001) begin bad++; $display("FAIL fetch_b_wrap: got %h want 0001", pred_target); end
        if_pc = 16'h0020; if_instr = 16'hB9FE; #1;
        total++;
        if (pred_target !== 16'h001F) begin bad++; $display("FAIL fetch_neg_disp: got %h want 001f", pred_target); end
    endtask

    task automatic test_mispredict();
        obs_t e, g;
        exec(1, 1, 16'h0010, 16'hB805, 0, 0, 1, 0, dummy);
        total++;
        if (flush !== 1'b1 || redirect_pc !== 16'h0016)
            begin bad++; $display("FAIL mispredict_redirect: got f=%b pc=%h want f=1 pc=0016", flush, redirect_pc); end
        if_pc = 16'h0010; if_instr = 16'hB805; #1;
        total++;
        if (pred_taken !== 1'b1) begin bad++; $display("FAIL mispredict_retrain: got %b want 1", pred_taken); end
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL mispredict_seq: got %h want %h", g, e); end
        end
    endtask

    task automatic test_squash();
        obs_t e, g;
        exec(1, 1, 16'h0020, 16'hB9FE, 1, 1, 0, 1, dummy);
        total++;
        if (flush !== 1'b1 || redirect_pc !== 16'h0021)
            begin bad++; $display("FAIL squash_blt: got f=%b pc=%h want f=1 pc=0021", flush, redirect_pc); end
        exec(1, 1, 16'h0030, 16'hBB00, 0, 0, 0, 0, dummy);
        total++;
        if (flush !== 1'b0 || br_count !== 16'd2 || mispred_count !== 16'd2)
            begin bad++; $display("FAIL squash_bne: got f=%b br=%0d mis=%0d want f=0 br=2 mis=2", flush, br_count, mispred_count); end
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL squash_seq: got %h want %h", g, e); end
        end
    endtask

    task automatic test_uncond();
        obs_t e, g;
        exec(1, 1, 16'hFFFF, 16'hA001, 1, 0, 0, 0, dummy);
        total++;
        if (flush !== 1'b0 || br_count !== 16'd3)
            begin bad++; $display("FAIL uncond_resolve: got f=%b br=%0d want f=0 br=3", flush, br_count); end
        if_pc = 16'h000F; if_instr = 16'hB800; #1;
        total++;
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL uncond_no_train: got %b want 0", pred_taken); end
        exec(1, 1, 16'h0010, 16'hBC05, 1, 0, 1, 0, dummy);
        exec(0, 1, 16'h0010, 16'hB805, 0, 0, 1, 0, dummy);
        exec(1, 0, 16'h0010, 16'hB805, 0, 0, 1, 0, dummy);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL uncond_seq: got %h want %h", g, e); end
        end
    endtask

    task automatic test_saturate();
        obs_t e, g;
        logic pre, old;
        for (int i = 0; i < 9; i++) begin
            logic tk;
            tk = (i < 4) || (i == 8);
            if_pc = 16'h0003; if_instr = 16'hB800;
            old = m_bht[3][1];
            exec(1, 1, 16'h0003, 16'hB800, tk, 0, tk, 0, pre);
            total++;
            if (pre !== old) begin bad++; $display("FAIL sat_same_cycle %0d: got %b want %b", i, pre, old); end
            total++;
            if (pred_taken !== m_bht[3][1]) begin bad++; $display("FAIL sat_pred %0d: got %b want %b", i, pred_taken, m_bht[3][1]); end
            if (i == 3) begin
                total++;
                if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_high: got %b want 1", pred_taken); end
            end
            if (i == 7) begin
                total++;
                if (pred_taken !== 1'b0) begin bad++; $display("FAIL sat_low: got %b want 0", pred_taken); end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL sat_seq: got %h want %h", g, e); end
        end
    endtask

    task automatic test_counters_reset();
        obs_t e, g;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            exec(1, 1, 16'h0040, 16'hA000, 0, 0, 0, 0, dummy);
            idle();
        end
        total++;
        if (br_count_s !== 2'd3 || mispred_count_s !== 2'd3 || br_count !== 16'd5)
            begin bad++; $display("FAIL cnt_saturate: got brs=%0d miss=%0d br=%0d want 3 3 5", br_count_s, mispred_count_s, br_count); end
        exec(1, 1, 16'h0010, 16'hB805, 0, 0, 1, 0, dummy);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL cnt_seq: got %h want %h", g, e); end
        end
        #2 rst_n = 0;
        #1;
        if_pc = 16'h0010; if_instr = 16'hB805; #1;
        total++;
        if (flush !== 0 || redirect_pc !== 0 || br_count !== 0 || mispred_count !== 0 || br_count_s !== 0)
            begin bad++; $display("FAIL async_reset: got f=%b pc=%h br=%0d mis=%0d want all 0", flush, redirect_pc, br_count, mispred_count); end
        total++;
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL async_reset_bht: got %b want 0", pred_taken); end
        apply_reset();
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL post_reset_seq: got %h want %h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_mispredict();
        test_squash();
        test_uncond();
        test_saturate();
        test_counters_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
